sync_ram_param_fill: RTL
========================

// Module: sync_ram_param_fill
// PURPOSE
//   Parametrised single-port synchronous RAM with a built-in bulk-fill sequencer.
//   Stores the memory-game sequence and clears or preloads it without datapath involvement.
//   The fill runs automatically after reset, or on request from the game FSM.
//   It replaces the fixed 16x4 RAM in the memory-game datapath.
// PARAMETERS
//   DATA_W        4    data word width in bits
//   ADDR_W        4    address width in bits
//   DEPTH         16   number of words implemented; 1 <= DEPTH <= 2**ADDR_W
//   FILL_ON_RESET 1    1: a fill with FILL_VALUE starts automatically on reset release
//   FILL_VALUE    0    fill word (DATA_W bits) used by the reset-triggered fill
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous reset, active-high
//   we          in   1       write enable; honoured only when busy=0
//   data        in   DATA_W  write data
//   addr        in   ADDR_W  read/write address
//   q           out  DATA_W  registered read data
//   fill_start  in   1       request a fill of every word with fill_data; sampled in IDLE only
//   fill_data   in   DATA_W  fill word; latched on an accepted fill_start
//   busy        out  1       1 while a fill is in progress
//   fill_done   out  1       one-cycle pulse on the cycle after the last fill write
// BEHAVIOUR
//   Reset values and scope
//   - Reset sets q=0, fill_done=0 and fill counter=0.
//   - busy=FILL_ON_RESET; FSM goes to FILL if FILL_ON_RESET=1, otherwise IDLE.
//   - Fill word register resets to FILL_VALUE.
//   - Memory array contents are NOT reset; only the fill sequence clears them.
//   FSM states
//   - IDLE: normal access.
//     - fill_start=1: latch fill_data, clear counter, go to FILL; busy=1 from the next cycle.
//   - FILL: at each edge, write the fill word to ram[cnt] and increment cnt.
//     - At cnt==DEPTH-1: do the write, go to IDLE, busy->0 and fill_done=1 for exactly 1 cycle.
//     - The fill takes exactly DEPTH cycles.
//   Access in IDLE, with 1-cycle latency
//   - we=1: ram[addr]<=data and q<=data (write-first: new data on the same-address read).
//   - we=0: q<=ram[addr].
//   - addr>=DEPTH: writes are dropped and q<=0.
//   Access in FILL
//   - we is ignored (the write is lost, with no error flag) and q holds its last value.
//   - fill_start is ignored.
//   Boundary and simultaneous events
//   - we and fill_start in the same IDLE cycle: the write completes at that edge.
//     The fill starts next and later overwrites it.
//   - reset asserted mid-fill: the fill aborts immediately; partially filled contents remain.
//     If FILL_ON_RESET=1, a fresh fill from address 0 with FILL_VALUE starts on reset release.
//   - The counter is ADDR_W+1 bits wide, so DEPTH=2**ADDR_W terminates without wrapping.
//   - fill_done never coincides with busy=1.
// TESTING
//   - FILL_ON_RESET=1, FILL_VALUE=4'h0: release reset, wait 16 cycles.
//     -> busy falls and fill_done pulses once; reading addr 0..15 returns 0 with 1-cycle latency.
//   - IDLE: write 4'hA@3, then read addr 3.
//     -> q=4'hA on the edge after the read; same-cycle we=1,data=4'h5,addr=7 -> q=4'h5 next cycle.
//   - fill_start=1 with fill_data=4'hF; assert we=1,data=4'h2,addr=1 during the fill.
//     -> busy=1 for 16 cycles; all words read 4'hF; the write is lost; q frozen during busy.
//   - Assert reset at fill cycle 5 for 2 cycles.
//     -> q=0 and busy=1 during reset; a full 16-cycle fill restarts at addr 0; fill_done pulses once.
//   - DEPTH=12, ADDR_W=4: write 4'h9@13, then read 13.
//     -> q=0; the fill takes 12 cycles; addr 11 is filled.
//   - fill_start held high continuously.
//     -> back-to-back fills, one idle cycle (fill_done) between them; no fill_start accepted while busy.

Source files
------------

// File: rtl/sync_ram_param_fill.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_param_fill
// Purpose  : Single-port synchronous RAM with a built-in bulk-fill sequencer.
//            Holds the memory-game sequence; clears or preloads it on reset
//            release or on request, without involving the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ram_param_fill #(
  parameter int              DATA_W        = 4,
  parameter int              ADDR_W        = 4,
  parameter int              DEPTH         = 16,
  parameter bit              FILL_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VALUE  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              fill_done
);

  // One extra counter bit lets DEPTH == 2**ADDR_W be expressed without wrap.
  localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];
  localparam int              c_LAST_I = DEPTH - 1;
  localparam logic [ADDR_W:0] c_LAST  = c_LAST_I[ADDR_W:0];

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic [DATA_W-1:0]   r_fill_word;
  logic [DATA_W-1:0]   r_q;
  logic                r_busy;
  logic                r_fill_done;
  logic                w_addr_ok;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_din;
  logic                w_latch;
  logic                w_last;

  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

  assign w_addr_ok = ({1'b0, addr} < c_DEPTH);
  assign q         = r_q;
  assign busy      = r_busy;
  assign fill_done = r_fill_done;

  // Next-state, memory write port selection and fill-counter advance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = addr;
    w_mem_din   = data;
    w_latch     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A same-cycle user write completes here; the fill overwrites it later.
        if (we && w_addr_ok) begin
          w_mem_we = 1'b1;
        end
        if (fill_start) begin
          w_state_nxt = S_FILL;
          w_cnt_nxt   = '0;
          w_latch     = 1'b1;
        end
      end
      S_FILL: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt[ADDR_W-1:0];
        w_mem_din  = r_fill_word;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_IDLE;
          w_last      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, fill word, status flags and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FILL_ON_RESET ? S_FILL : S_IDLE;
      r_cnt       <= '0;
      r_fill_word <= FILL_VALUE;
      r_busy      <= FILL_ON_RESET;
      r_fill_done <= 1'b0;
      r_q         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_state_nxt == S_FILL);
      r_fill_done <= w_last;
      if (w_latch) begin
        r_fill_word <= fill_data;
      end
      // Read data only moves in IDLE; it is frozen while a fill runs.
      if (r_state == S_IDLE) begin
        if (!w_addr_ok) begin
          r_q <= '0;
        end else if (we) begin
          r_q <= data;
        end else begin
          r_q <= r_mem[addr];
        end
      end
    end
  end

  // Storage array: never reset, and not written while reset is held.
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

endmodule
`default_nettype wire
